// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the alu and its arbiter/sequencer.
//   alu_op_e    : 4-bit opcode map understood by the alu (ADD..SRL)
//   arb_state_e : sequencer FSM states
//   ALU_OP_MAX  : highest defined opcode; anything above returns 0
//   is_slow()   : opcodes that hold the alu for SLOW_LAT EXEC cycles
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_NOT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [3:0] ALU_OP_MAX = 4'd8;

  function automatic logic is_slow(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational N-bit alu.
//   i_op [3:0] : opcode (alu_op_e); 9-15 produce 0
//   i_a, i_b   : operands
//   o_y        : result, low N bits (ADD carry and MUL upper half dropped)
// Division by zero yields all ones so the output is always a known value.
module alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [3:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_MUL: o_y = i_a * i_b;
      ALU_DIV: o_y = (i_b == '0) ? '1 : (i_a / i_b);
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_NOT: o_y = ~i_a;
      ALU_SLL: o_y = i_a << i_b;
      ALU_SRL: o_y = i_a >> i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-requester round-robin grant.
//   req[1:0]   : request vector
//   last_grant : index granted most recently
//   gnt[1:0]   : one-hot grant (or zero when nothing requests)
// On a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] |  last_grant);
  assign gnt[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two requesters.
// Accepts one op at a time (valid/ready), latches it, holds the alu inputs
// for 1 or SLOW_LAT cycles, registers the result and returns it tagged with
// the requester id over a valid/ready response channel.
//   clk, rst             : clock, async active-high reset
//   req_valid/req_ready  : per-requester request handshake (ready one-hot)
//   req_op*/req_a*/req_b*: opcode and operands of requester 0 / 1
//   rsp_valid/rsp_ready  : response handshake
//   rsp_result, rsp_id   : registered result and issuing requester
//   busy                 : FSM not in IDLE
// Optional macro ALU_ARB_ERR_EN adds rsp_err: flags op>8 or DIV by zero,
// forces the result to 0 and shortens EXEC to one cycle for such ops.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N        = 8,
  parameter int SLOW_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [3:0]   req_op0,
  input  logic [3:0]   req_op1,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_b1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_id,
  output logic         busy
`ifdef ALU_ARB_ERR_EN
  ,
  output logic         rsp_err
`endif
);

  localparam int CW = (SLOW_LAT > 1) ? $clog2(SLOW_LAT) : 1;
  localparam logic [CW-1:0] CNT_SLOW = CW'(SLOW_LAT - 1);

  arb_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]   r_op;
  logic [N-1:0] r_a, r_b;
  logic         r_id, r_last;

  logic [1:0]   w_gnt;
  logic         w_sel, w_acc, w_fin, w_rsp_done;
  logic [3:0]   w_op_in;
  logic [N-1:0] w_a_in, w_b_in, w_alu_y;
  logic [CW-1:0] w_cnt_ld;

  rr_arb2 u_rr_arb2 (
    .req        (req_valid),
    .last_grant (r_last),
    .gnt        (w_gnt)
  );

  // alu sees only the latched operands, so req_* may change after accept
  alu #(.N(N)) u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_alu_y)
  );

  assign w_sel   = w_gnt[1];
  assign w_op_in = w_sel ? req_op1 : req_op0;
  assign w_a_in  = w_sel ? req_a1  : req_a0;
  assign w_b_in  = w_sel ? req_b1  : req_b0;
  assign busy    = (r_state != ST_IDLE);

`ifdef ALU_ARB_ERR_EN
  logic w_err_in, r_err;
  assign w_err_in = (w_op_in > ALU_OP_MAX) || ((w_op_in == ALU_DIV) && (w_b_in == '0));
  // errored ops skip the long latency
  assign w_cnt_ld = (is_slow(w_op_in) && !w_err_in) ? CNT_SLOW : '0;
`else
  assign w_cnt_ld = is_slow(w_op_in) ? CNT_SLOW : '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    w_acc       = 1'b0;
    w_fin       = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_gnt;
        if (|(req_valid & w_gnt)) begin
          w_acc       = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= 1'b0;
      r_last     <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
    end else begin
      if (w_acc) begin
        r_op   <= w_op_in;
        r_a    <= w_a_in;
        r_b    <= w_b_in;
        r_id   <= w_sel;
        r_last <= w_sel;
        r_cnt  <= w_cnt_ld;
      end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fin) begin
`ifdef ALU_ARB_ERR_EN
        rsp_result <= r_err ? '0 : w_alu_y;
`else
        rsp_result <= w_alu_y;
`endif
        rsp_id    <= r_id;
        rsp_valid <= 1'b1;
      end else if (w_rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (w_acc) r_err   <= w_err_in;
      if (w_fin) rsp_err <= r_err;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int N = 8;
  localparam int SLOW_LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready;
  logic [3:0]   req_op0, req_op1;
  logic [N-1:0] req_a0, req_a1, req_b0, req_b1;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [N-1:0] rsp_result;
`ifdef ALU_ARB_ERR_EN
  logic         rsp_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  alu_arbiter #(.N(N), .SLOW_LAT(SLOW_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy)
`ifdef ALU_ARB_ERR_EN
    , .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  // single op from requester idx; checks grant, latency, result, id
  task automatic do_op(input string tag, input logic idx, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input int lat, input logic exp_err);
    int k;
    if (idx) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else     begin req_op0 = op; req_a0 = a; req_b0 = b; end
    req_valid = idx ? 2'b10 : 2'b01;
    rsp_ready = 1'b1;
    #1;
    k = 0;
    while (!req_ready[idx] && k < 10) begin tick(); k++; end
    chk({tag, "_acc"}, {30'd0, req_ready}, idx ? 32'd2 : 32'd1);
    tick();
    // scramble inputs after accept; in-flight op must not notice
    req_valid = 2'b00;
    req_op0 = 4'hF; req_op1 = 4'hF; req_a0 = ~a; req_a1 = ~a; req_b0 = ~b; req_b1 = ~b;
    k = 1;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    chk({tag, "_lat"}, k, 1 + lat);
    chk({tag, "_res"}, {24'd0, rsp_result}, {24'd0, exp});
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, idx});
`ifdef ALU_ARB_ERR_EN
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
`else
    if (exp_err) $display("note: %s error flag not built", tag);
`endif
    tick();
    chk({tag, "_done"}, {30'd0, rsp_valid, busy}, 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    #1;
    tick();
    // reset values
    req_valid = 2'b01; #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_res", {24'd0, rsp_result}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    req_valid = 2'b00;
    do_reset();

    // first op: ADD wraps, accepted immediately
    do_op("add", 1'b0, 4'd0, 8'd200, 8'd100, 8'd44, 1, 1'b0);

    // both valid continuously -> 0,1,0,1
    do_reset();
    req_op0 = 4'd1; req_a0 = 8'd9;    req_b0 = 8'd4;
    req_op1 = 4'd4; req_a1 = 8'hF0;   req_b1 = 8'h3C;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("alt_gnt", {30'd0, req_ready}, (i % 2) ? 32'd2 : 32'd1);
      tick();
      chk("alt_exec_rdy", {30'd0, req_ready}, 32'd0);
      tick();
      chk("alt_rv", {31'd0, rsp_valid}, 32'd1);
      chk("alt_res", {24'd0, rsp_result}, (i % 2) ? 32'h30 : 32'h05);
      chk("alt_id", {31'd0, rsp_id}, (i % 2) ? 32'd1 : 32'd0);
      tick();
    end
    req_valid = 2'b00; rsp_ready = 1'b0;
    #1;

    // MUL latency then stalled response
    req_op0 = 4'd2; req_a0 = 8'd15; req_b0 = 8'd17; req_valid = 2'b01;
    #1;
    chk("mul_acc", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      chk("mul_wait", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    chk("mul_rv", {31'd0, rsp_valid}, 32'd1);
    chk("mul_res", {24'd0, rsp_result}, 32'hFF);
    chk("mul_id", {31'd0, rsp_id}, 32'd0);
    req_op1 = 4'd0; req_a1 = 8'd1; req_b1 = 8'd2; req_valid = 2'b10;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rv", {31'd0, rsp_valid}, 32'd1);
      chk("hold_res", {24'd0, rsp_result}, 32'hFF);
      chk("hold_id", {31'd0, rsp_id}, 32'd0);
      chk("hold_rdy", {30'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1; #1;
    chk("resp_rdy", {30'd0, req_ready}, 32'd0);
    tick();
    rsp_ready = 1'b0; #1;
    chk("next_rv", {31'd0, rsp_valid}, 32'd0);
    chk("next_gnt", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    tick();
    chk("next_res", {24'd0, rsp_result}, 32'd3);
    chk("next_id", {31'd0, rsp_id}, 32'd1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; #1;

    // reset during DIV EXEC
    req_op0 = 4'd3; req_a0 = 8'd100; req_b0 = 8'd5; req_valid = 2'b01;
    #1;
    chk("div_acc", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b1; #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_norsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    req_valid = 2'b11; #1;
    chk("abort_gnt", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00; #1;

    // opcode table
    do_op("sub", 1'b1, 4'd1, 8'd3,   8'd5, 8'hFE, 1, 1'b0);
    do_op("or",  1'b0, 4'd5, 8'hA0, 8'h05, 8'hA5, 1, 1'b0);
    do_op("not", 1'b1, 4'd6, 8'h3C, 8'h00, 8'hC3, 1, 1'b0);
    do_op("sll", 1'b0, 4'd7, 8'h81, 8'd1,  8'h02, 1, 1'b0);
    do_op("srl", 1'b1, 4'd8, 8'h80, 8'd3,  8'h10, 1, 1'b0);
    do_op("div", 1'b0, 4'd3, 8'd100, 8'd7, 8'd14, SLOW_LAT, 1'b0);
    do_op("mul", 1'b1, 4'd2, 8'd16, 8'd17, 8'h10, SLOW_LAT, 1'b0);
`ifdef ALU_ARB_ERR_EN
    do_op("op12", 1'b0, 4'hC, 8'd5, 8'd6, 8'd0, 1, 1'b1);
    do_op("div0", 1'b1, 4'd3, 8'd7, 8'd0, 8'd0, 1, 1'b1);
`else
    do_op("op12", 1'b0, 4'hC, 8'd5, 8'd6, 8'd0, 1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
